// File: rtl/rf_write_sequencer.sv
// rf_write_sequencer: clears X0..X30 after reset, then arbitrates the register-file write port between writeback and debug
module rf_write_sequencer #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_WriteRegister,
    input  logic [63:0] wb_WriteData,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_addr,
    input  logic [63:0] dbg_data,
    output logic        dbg_ready,
    output logic        wb_stall,
    output logic        init_busy,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData
);
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t      r_state, w_state_nxt;
    logic [4:0]  r_clr_cnt, w_clr_nxt;
    logic [3:0]  r_starve_cnt, w_starve_nxt;
    logic        w_we;
    logic        w_force;
    // State, clear counter and starvation counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            r_clr_cnt    <= 5'd0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_cnt    <= w_clr_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end
    // Source selection, handshake and next-state; writes to X31 are swallowed but still complete
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_nxt     = r_clr_cnt;
        w_starve_nxt  = 4'd0;
        w_we          = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 64'd0;
        dbg_ready     = 1'b0;
        wb_stall      = 1'b0;
        init_busy     = 1'b0;
        w_force       = (r_starve_cnt == LIMIT) && dbg_valid;
        if (r_state == S_CLEAR) begin
            w_we          = 1'b1;
            WriteRegister = r_clr_cnt;
            init_busy     = 1'b1;
            wb_stall      = 1'b1;
            w_clr_nxt     = r_clr_cnt + 5'd1;
            w_state_nxt   = (r_clr_cnt == 5'd30) ? S_RUN : S_CLEAR;
        end else if (w_force || (!wb_RegWrite && dbg_valid)) begin
            w_we          = 1'b1;
            WriteRegister = dbg_addr;
            WriteData     = dbg_data;
            dbg_ready     = 1'b1;
            wb_stall      = w_force;
        end else if (wb_RegWrite) begin
            w_we          = 1'b1;
            WriteRegister = wb_WriteRegister;
            WriteData     = wb_WriteData;
            w_starve_nxt  = !dbg_valid ? 4'd0 : (r_starve_cnt == LIMIT) ? LIMIT : r_starve_cnt + 4'd1;
        end
        RegWrite = w_we && (WriteRegister != 5'd31) && !reset;
        if (reset) begin
            dbg_ready = 1'b0;
            wb_stall  = 1'b1;
            init_busy = 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_write_sequencer.sv
// tb_rf_write_sequencer: table-driven and scoreboard checks of the register-file write sequencer
module tb_rf_write_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_RegWrite;
    logic [4:0]  wb_WriteRegister;
    logic [63:0] wb_WriteData;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic        dbg_ready, wb_stall, init_busy, RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        dv;
        logic [4:0]  da;
        logic [63:0] dd;
        logic        e_we;
        logic [4:0]  e_a;
        logic [63:0] e_d;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    vec_t        vt[$];
    logic [68:0] sb[$];
    int          total = 0;
    int          bad = 0;

    rf_write_sequencer #(.CLEAR_ON_RESET(1'b1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_RegWrite(wb_RegWrite), .wb_WriteRegister(wb_WriteRegister), .wb_WriteData(wb_WriteData),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_ready(dbg_ready), .wb_stall(wb_stall), .init_busy(init_busy),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wb_we, input logic [4:0] wa, input logic [63:0] wd,
                                input logic dv, input logic [4:0] da, input logic [63:0] dd,
                                input logic e_we, input logic [4:0] e_a, input logic [63:0] e_d,
                                input logic e_rdy, input logic e_stall);
        vec_t v;
        v.wb_we = wb_we; v.wa = wa; v.wd = wd; v.dv = dv; v.da = da; v.dd = dd;
        v.e_we = e_we; v.e_a = e_a; v.e_d = e_d; v.e_rdy = e_rdy; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic dv, input logic [4:0] da, input logic [63:0] dd);
        wb_RegWrite = we; wb_WriteRegister = wa; wb_WriteData = wd;
        dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", RegWrite, 1'b0);
        chk("rst_rdy", dbg_ready, 1'b0);
        chk("rst_stall", wb_stall, 1'b1);
        chk("rst_busy", init_busy, 1'b1);
    endtask

    // n clear cycles starting at the current negedge with reset low
    task automatic clear_run(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("clr_busy", init_busy, 1'b1);
            chk("clr_stall", wb_stall, 1'b1);
            chk("clr_rdy", dbg_ready, 1'b0);
            chk("clr_we", RegWrite, 1'b1);
            chk("clr_addr", WriteRegister, 64'(i));
            chk("clr_data", WriteData, 64'd0);
            sb.push_back({5'(i), 64'd0});
            @(negedge clk);
        end
    endtask

    // Every rising edge retires the expected write of this cycle, if any
    always @(posedge clk) begin
        logic [68:0] e;
        chk("sb_we", RegWrite, sb.size() != 0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (RegWrite) begin
                chk("sb_addr", WriteRegister, 64'(e[68:64]));
                chk("sb_data", WriteData, e[63:0]);
            end
        end
    end

    initial begin
        vt.push_back(mk(1, 3,  64'h1234, 0, 0,  0,         1, 3,  64'h1234, 0, 0));
        vt.push_back(mk(0, 0,  0,        1, 7,  64'hAA,    1, 7,  64'hAA,   1, 0));
        vt.push_back(mk(0, 0,  0,        1, 31, 64'hBB,    0, 0,  0,        1, 0));
        vt.push_back(mk(0, 0,  0,        0, 0,  0,         0, 0,  0,        0, 0));
        vt.push_back(mk(1, 31, 64'h5,    0, 0,  0,         0, 0,  0,        0, 0));
        vt.push_back(mk(1, 10, 64'h55,   1, 12, 64'h66,    1, 10, 64'h55,   0, 0));
        vt.push_back(mk(0, 0,  0,        1, 12, 64'h66,    1, 12, 64'h66,   1, 0));
        for (int i = 1; i <= 4; i++)
            vt.push_back(mk(1, 5'(i), 64'(i * 16), 1, 20, 64'hBEEF, 1, 5'(i), 64'(i * 16), 0, 0));
        vt.push_back(mk(1, 21, 64'h500,  1, 20, 64'hBEEF,  1, 20, 64'hBEEF,  1, 1));
        vt.push_back(mk(1, 21, 64'h500,  0, 0,  0,         1, 21, 64'h500,   0, 0));
        vt.push_back(mk(1, 1,  64'h11,   1, 9,  64'h99,    1, 1,  64'h11,    0, 0));
        vt.push_back(mk(1, 2,  64'h22,   1, 9,  64'h99,    1, 2,  64'h22,    0, 0));
        vt.push_back(mk(1, 3,  64'h33,   0, 0,  0,         1, 3,  64'h33,    0, 0));
        for (int i = 4; i <= 7; i++)
            vt.push_back(mk(1, 5'(i), 64'(i), 1, 9, 64'h99, 1, 5'(i), 64'(i), 0, 0));
        vt.push_back(mk(1, 8,  64'h88,   1, 9,  64'h99,    1, 9,  64'h99,    1, 1));
        vt.push_back(mk(1, 8,  64'h88,   1, 13, 64'h77,    1, 8,  64'h88,    0, 0));
        vt.push_back(mk(0, 0,  0,        0, 0,  0,         0, 0,  0,         0, 0));
        reset = 1'b1;
        drive(1, 5, 64'hDEAD, 1, 6, 64'hBAD);
        @(negedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        clear_run(31);
        foreach (vt[k]) begin
            drive(vt[k].wb_we, vt[k].wa, vt[k].wd, vt[k].dv, vt[k].da, vt[k].dd);
            #1;
            chk($sformatf("v%0d_busy", k), init_busy, 1'b0);
            chk($sformatf("v%0d_we", k), RegWrite, vt[k].e_we);
            chk($sformatf("v%0d_rdy", k), dbg_ready, vt[k].e_rdy);
            chk($sformatf("v%0d_stall", k), wb_stall, vt[k].e_stall);
            if (vt[k].e_we) begin
                chk($sformatf("v%0d_addr", k), WriteRegister, 64'(vt[k].e_a));
                chk($sformatf("v%0d_data", k), WriteData, vt[k].e_d);
                sb.push_back({vt[k].e_a, vt[k].e_d});
            end
            @(negedge clk);
        end
        drive(1, 4, 64'h44, 1, 2, 64'h22);
        reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        clear_run(12);
        reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        clear_run(31);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("run_busy", init_busy, 1'b0);
        chk("run_stall", wb_stall, 1'b0);
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
